// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - master state encoding, bus direction and slave address constants
package i2c_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_STARTC   = 4'd1;
  localparam state_t ST_ADDR     = 4'd2;
  localparam state_t ST_ADDR_ACK = 4'd3;
  localparam state_t ST_TX_DATA  = 4'd4;
  localparam state_t ST_TX_ACK   = 4'd5;
  localparam state_t ST_RX_DATA  = 4'd6;
  localparam state_t ST_RX_NACK  = 4'd7;
  localparam state_t ST_STOPC    = 4'd8;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;

  localparam logic [6:0] SW_SLAVE_ADDR = 7'h57;

  function automatic int qtr_cycles(input int clk_hz, input int scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// rtl/i2c_qtr_tick.sv - quarter-period tick generator with a stretch hold point
module i2c_qtr_tick #(
  parameter int QTR      = 250,
  parameter int SYNC_CNT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int W = $clog2(QTR);

  logic [W-1:0] cnt;
  logic         freeze;
  logic         wrap;

  // Hold is honoured only once the synchronized SCL readback reflects this quarter's SCL level.
  assign freeze = hold && (cnt == W'(SYNC_CNT));
  assign wrap   = (cnt == W'(QTR - 1));
  assign tick   = run && !freeze && wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (!freeze) begin
      if (wrap) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_read_master.sv
// rtl/i2c_read_master.sv - single-transaction I2C master (optional I2C_MASTER_CLK_STRETCH_EN)
import i2c_pkg::*;

module i2c_read_master #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int SCL_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic       rw,
  input  logic [7:0] tx_data,
  output logic       scl,
  input  logic       scl_in,
  inout  wire        sda,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rx_data
);

  localparam int QTR = qtr_cycles(CLK_FREQ_HZ, SCL_FREQ_HZ);

  state_t     state;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [7:0] sh;
  logic [7:0] rx_sh;
  logic [7:0] tx_r;
  logic       rw_r;
  logic       samp;
  logic       tick;
  logic       hold;
  logic       run;
  logic       sda_low;

  assign run = (state != ST_IDLE);

`ifdef I2C_MASTER_CLK_STRETCH_EN
  logic scl_s1, scl_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
    end
  end

  assign hold = !scl_s2 && ((state == ST_STOPC) ? (q == 2'd1) : (q == 2'd2));
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign hold          = 1'b0;
`endif

  i2c_qtr_tick #(.QTR(QTR), .SYNC_CNT(2)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .hold  (hold),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      q       <= 2'd0;
      bit_cnt <= 3'd0;
      sh      <= 8'h00;
      rx_sh   <= 8'h00;
      tx_r    <= 8'h00;
      rw_r    <= 1'b0;
      samp    <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rx_data <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          state   <= ST_STARTC;
          q       <= 2'd0;
          busy    <= 1'b1;
          ack_err <= 1'b0;
          sh      <= {slave_addr, rw};
          rw_r    <= rw;
          tx_r    <= tx_data;
        end
      end else if (tick) begin
        q <= q + 2'd1;
        if (q == 2'd2) begin
          samp <= sda;
          if (state == ST_RX_DATA) rx_sh <= {rx_sh[6:0], sda};
        end
        if (q == 2'd3) begin
          case (state)
            ST_STARTC: begin
              state   <= ST_ADDR;
              bit_cnt <= 3'd7;
            end
            ST_ADDR: begin
              if (bit_cnt == 3'd0) state <= ST_ADDR_ACK;
              else begin
                bit_cnt <= bit_cnt - 3'd1;
                sh      <= {sh[6:0], 1'b0};
              end
            end
            ST_ADDR_ACK: begin
              bit_cnt <= 3'd7;
              if (samp) begin
                ack_err <= 1'b1;
                state   <= ST_STOPC;
              end else if (rw_r == I2C_READ) begin
                state <= ST_RX_DATA;
              end else begin
                state <= ST_TX_DATA;
                sh    <= tx_r;
              end
            end
            ST_TX_DATA: begin
              if (bit_cnt == 3'd0) state <= ST_TX_ACK;
              else begin
                bit_cnt <= bit_cnt - 3'd1;
                sh      <= {sh[6:0], 1'b0};
              end
            end
            ST_TX_ACK: begin
              if (samp) ack_err <= 1'b1;
              state <= ST_STOPC;
            end
            ST_RX_DATA: begin
              if (bit_cnt == 3'd0) state <= ST_RX_NACK;
              else bit_cnt <= bit_cnt - 3'd1;
            end
            ST_RX_NACK: begin
              rx_data <= rx_sh;
              state   <= ST_STOPC;
            end
            ST_STOPC: begin
              state <= ST_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Bus levels derive straight from reset-to-idle state, so an async reset frees the bus at once.
  always_comb begin
    scl     = 1'b1;
    sda_low = 1'b0;
    case (state)
      ST_STARTC: sda_low = q[1];
      ST_ADDR, ST_TX_DATA: begin
        scl     = q[1];
        sda_low = ~sh[7];
      end
      ST_ADDR_ACK, ST_TX_ACK, ST_RX_DATA, ST_RX_NACK: scl = q[1];
      ST_STOPC: begin
        scl     = (q != 2'd0);
        sda_low = ~q[1];
      end
      default: ;
    endcase
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_read_master.sv
// tb/tb_i2c_read_master.sv - self-checking bench with a bus-level slave model
module tb_i2c_read_master;
  import i2c_pkg::*;

  localparam int QTR     = 4;
  localparam int FULL    = 80 * QTR;
  localparam int NACKLEN = 44 * QTR;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic       rw = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       scl;
  logic       scl_in;
  logic       busy, done, ack_err;
  logic [7:0] rx_data;
  wire        sda_bus;

  logic stretch_low = 1'b0;
  logic slave_low = 1'b0;

  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;
  assign scl_in  = scl & ~stretch_low;

  always #5 clk = ~clk;

  i2c_read_master #(.CLK_FREQ_HZ(1_600_000), .SCL_FREQ_HZ(100_000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_addr(slave_addr), .rw(rw),
    .tx_data(tx_data), .scl(scl), .scl_in(scl_in), .sda(sda_bus),
    .busy(busy), .done(done), .ack_err(ack_err), .rx_data(rx_data)
  );

  int tests_run = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: decodes START/STOP and bits from bus edges, one device at model_addr.
  logic [6:0] model_addr = 7'h57;
  logic [7:0] rd_byte = 8'h00;
  logic       ack_data = 1'b1;
  logic [7:0] captured = 8'h00;
  logic       master_ack_bit = 1'b0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         phase = 0;
  int         bitn = 0;
  logic [7:0] s_sh = 8'h00;
  logic       s_rw = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0;
      slave_low = 1'b0;
    end else if (p_scl && scl && p_sda && !sda_bus) begin
      start_cnt++;
      phase = 1; bitn = 0; slave_low = 1'b0;
    end else if (p_scl && scl && !p_sda && sda_bus) begin
      stop_cnt++;
      phase = 0; slave_low = 1'b0;
    end else if (!p_scl && scl) begin
      case (phase)
        1, 3: begin s_sh = {s_sh[6:0], sda_bus}; bitn++; end
        5: bitn++;
        6: master_ack_bit = sda_bus;
        default: ;
      endcase
    end else if (p_scl && !scl) begin
      case (phase)
        1: if (bitn == 8) begin
          if (s_sh[7:1] == model_addr) begin
            phase = 2; s_rw = s_sh[0]; slave_low = 1'b1;
          end else phase = 0;
        end
        2: begin
          bitn = 0;
          if (s_rw) begin phase = 5; slave_low = ~rd_byte[7]; end
          else begin phase = 3; slave_low = 1'b0; end
        end
        3: if (bitn == 8) begin captured = s_sh; phase = 4; slave_low = ack_data; end
        4: begin slave_low = 1'b0; phase = 0; end
        5: if (bitn == 8) begin phase = 6; slave_low = 1'b0; end
           else slave_low = ~rd_byte[7-bitn];
        6: phase = 0;
        default: ;
      endcase
    end
    p_scl = scl;
    p_sda = sda_bus;
  end

  logic [7:0] exp_rx = 8'h00;

  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                         output int dur, output logic busy_at_done);
    int acc;
    @(negedge clk);
    slave_addr = a; rw = r; tx_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = cyc;
    dur = -1;
    busy_at_done = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        dur = cyc - acc;
        busy_at_done = busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (scl !== 1'b1) begin fails++; $display("FAIL reset_scl got %b want 1", scl); end
    tests_run++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL reset_sda got %b want 1", sda_bus); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests_run++; if (ack_err !== 1'b0) begin fails++; $display("FAIL reset_ack_err got %b want 0", ack_err); end
    tests_run++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx got %h want 00", rx_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_switch();
    int dur, s0, p0;
    logic bd;
    model_addr = SW_SLAVE_ADDR; rd_byte = 8'hA5; exp_rx = 8'hA5;
    s0 = start_cnt; p0 = stop_cnt;
    run_txn(SW_SLAVE_ADDR, I2C_READ, 8'h00, dur, bd);
    tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL read_rx got %h want %h", rx_data, exp_rx); end
    tests_run++; if (ack_err !== 1'b0) begin fails++; $display("FAIL read_ack_err got %b want 0", ack_err); end
    tests_run++; if (dur != FULL) begin fails++; $display("FAIL read_len got %0d want %0d", dur, FULL); end
    tests_run++; if (master_ack_bit !== 1'b1) begin fails++; $display("FAIL read_nack got %b want 1", master_ack_bit); end
    tests_run++; if (start_cnt - s0 != 1) begin fails++; $display("FAIL read_starts got %0d want 1", start_cnt - s0); end
    tests_run++; if (stop_cnt - p0 != 1) begin fails++; $display("FAIL read_stops got %0d want 1", stop_cnt - p0); end
    tests_run++; if (bd !== 1'b0) begin fails++; $display("FAIL read_busy_at_done got %b want 0", bd); end
  endtask

  task automatic test_addr_nack();
    int dur, p0;
    logic bd;
    p0 = stop_cnt;
    run_txn(7'h22, I2C_READ, 8'h00, dur, bd);
    tests_run++; if (ack_err !== 1'b1) begin fails++; $display("FAIL nack_ack_err got %b want 1", ack_err); end
    tests_run++; if (dur != NACKLEN) begin fails++; $display("FAIL nack_len got %0d want %0d", dur, NACKLEN); end
    tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL nack_rx_hold got %h want %h", rx_data, exp_rx); end
    tests_run++; if (stop_cnt - p0 != 1) begin fails++; $display("FAIL nack_stops got %0d want 1", stop_cnt - p0); end
  endtask

  task automatic test_write();
    int dur;
    logic bd;
    model_addr = 7'h40; ack_data = 1'b1;
    run_txn(7'h40, I2C_WRITE, 8'h3C, dur, bd);
    tests_run++; if (captured !== 8'h3C) begin fails++; $display("FAIL write_data got %h want 3c", captured); end
    tests_run++; if (ack_err !== 1'b0) begin fails++; $display("FAIL write_ack_err got %b want 0", ack_err); end
    tests_run++; if (dur != FULL) begin fails++; $display("FAIL write_len got %0d want %0d", dur, FULL); end
    ack_data = 1'b0;
    run_txn(7'h40, I2C_WRITE, 8'h5E, dur, bd);
    tests_run++; if (captured !== 8'h5E) begin fails++; $display("FAIL wnack_data got %h want 5e", captured); end
    tests_run++; if (ack_err !== 1'b1) begin fails++; $display("FAIL wnack_ack_err got %b want 1", ack_err); end
    tests_run++; if (dur != FULL) begin fails++; $display("FAIL wnack_len got %0d want %0d", dur, FULL); end
  endtask

  task automatic test_random();
    int dur, exp_dur;
    logic bd, hit, r, exp_err;
    logic [6:0] a;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      hit = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      ack_data = 1'($urandom_range(0, 1));
      rd_byte = 8'($urandom);
      a = hit ? model_addr : (model_addr ^ 7'($urandom_range(1, 127)));
      exp_err = !hit || (!r && !ack_data);
      exp_dur = hit ? FULL : NACKLEN;
      if (hit && r) exp_rx = rd_byte;
      run_txn(a, r, d, dur, bd);
      tests_run++; if (ack_err !== exp_err) begin fails++; $display("FAIL rand%0d_ack_err got %b want %b", i, ack_err, exp_err); end
      tests_run++; if (dur != exp_dur) begin fails++; $display("FAIL rand%0d_len got %0d want %0d", i, dur, exp_dur); end
      tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL rand%0d_rx got %h want %h", i, rx_data, exp_rx); end
      if (hit && !r) begin
        tests_run++; if (captured !== d) begin fails++; $display("FAIL rand%0d_wdata got %h want %h", i, captured, d); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, dur, s0;
    logic extra_busy;
    model_addr = SW_SLAVE_ADDR; rd_byte = 8'h69; exp_rx = 8'h69;
    s0 = start_cnt;
    @(negedge clk);
    slave_addr = SW_SLAVE_ADDR; rw = I2C_READ; start = 1'b1;
    @(negedge clk);
    start = 1'b0; acc = cyc;
    repeat (9) @(negedge clk);
    slave_addr = 7'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dur = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin dur = cyc - acc; break; end
      @(negedge clk);
    end
    extra_busy = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (busy) extra_busy = 1'b1;
    end
    tests_run++; if (dur != FULL) begin fails++; $display("FAIL b2b_len got %0d want %0d", dur, FULL); end
    tests_run++; if (start_cnt - s0 != 1) begin fails++; $display("FAIL b2b_starts got %0d want 1", start_cnt - s0); end
    tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL b2b_rx got %h want %h", rx_data, exp_rx); end
    tests_run++; if (extra_busy !== 1'b0) begin fails++; $display("FAIL b2b_requeued got %b want 0", extra_busy); end
  endtask

  task automatic test_reset_mid();
    int rises, dur;
    logic pv, found, bd;
    model_addr = SW_SLAVE_ADDR; rd_byte = 8'h5A;
    @(negedge clk);
    slave_addr = SW_SLAVE_ADDR; rw = I2C_READ; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pv = scl; rises = 0; found = 1'b0;
    // 8 address + 1 ACK + 4 data rising edges precede the bit-3 slot.
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (scl && !pv) rises++;
      if (!scl && pv && rises == 13) found = 1'b1;
      pv = scl;
    end
    tests_run++; if (found !== 1'b1) begin fails++; $display("FAIL rstmid_reach got %b want 1", found); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (scl !== 1'b1) begin fails++; $display("FAIL rstmid_scl got %b want 1", scl); end
    tests_run++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL rstmid_sda got %b want 1", sda_bus); end
    tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_byte = 8'hC3; exp_rx = 8'hC3;
    run_txn(SW_SLAVE_ADDR, I2C_READ, 8'h00, dur, bd);
    tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL rstmid_rx got %h want %h", rx_data, exp_rx); end
    tests_run++; if (ack_err !== 1'b0) begin fails++; $display("FAIL rstmid_ack_err got %b want 0", ack_err); end
    tests_run++; if (dur != FULL) begin fails++; $display("FAIL rstmid_len got %0d want %0d", dur, FULL); end
  endtask

`ifdef I2C_MASTER_CLK_STRETCH_EN
  task automatic test_stretch();
    int rises, dur, acc;
    logic pv, found;
    model_addr = SW_SLAVE_ADDR; rd_byte = 8'h96; exp_rx = 8'h96;
    @(negedge clk);
    slave_addr = SW_SLAVE_ADDR; rw = I2C_READ; start = 1'b1;
    @(negedge clk);
    start = 1'b0; acc = cyc;
    pv = scl; rises = 0; found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (scl && !pv) rises++;
      if (scl && !pv && rises == 8) found = 1'b1;
      pv = scl;
    end
    stretch_low = 1'b1;
    repeat (50) @(negedge clk);
    stretch_low = 1'b0;
    dur = -1;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin dur = cyc - acc; break; end
      @(negedge clk);
    end
    tests_run++; if (found !== 1'b1) begin fails++; $display("FAIL stretch_reach got %b want 1", found); end
    tests_run++; if (dur != FULL + 50) begin fails++; $display("FAIL stretch_len got %0d want %0d", dur, FULL + 50); end
    tests_run++; if (rx_data !== exp_rx) begin fails++; $display("FAIL stretch_rx got %h want %h", rx_data, exp_rx); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_switch();
    test_addr_nack();
    test_write();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_MASTER_CLK_STRETCH_EN
    test_stretch();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
